// File: rtl/spi_prog_master.sv
// SPI mode-0 word transmitter for the on-chip programmer (SDI/SCLK/CS).
// Sends one DATA_W-bit word LSB first; receiver shifts on SCLK rise.
//
// Optional feature: define PROG_MASTER_BOOT_EN to self-send BOOT_WORD
// once, in the first clk cycle after each reset release.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous reset, active low
//   start    send request, accepted only while busy=0
//   data_in  word to send, captured on the accept cycle
//   busy     high from the cycle after accept until the done cycle
//   done     one-cycle pulse once the word and the CS gap are complete
//   SCLK     SPI clock, idles low
//   CS       chip select, active low, idles high
//   SDO      serial data to the programmer SDI, idles 0
module spi_prog_master #(
    parameter int                 DATA_W    = 66,
    parameter int                 CLK_DIV   = 4,
    parameter int                 CS_GAP    = 2,
    parameter logic [DATA_W-1:0]  BOOT_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              SCLK,
    output logic              CS,
    output logic              SDO
);

    localparam int GAP_N = CS_GAP * CLK_DIV;
    localparam int CNT_W = $clog2(GAP_N + 1);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    // The done cycle itself counts as the last cycle of the CS gap.
    localparam bit GAP_SKIP = (GAP_N == 1);
    localparam int GAP_END  = (GAP_N >= 2) ? GAP_N - 2 : 0;

`ifdef PROG_MASTER_BOOT_EN
    localparam bit BOOT = 1'b1;
`else
    localparam bit BOOT = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, SETUP, HIGH, LOW, HOLD, GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              sdo_q, sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              boot_q;

    logic              phase_end;
    logic              go;
    logic [DATA_W-1:0] word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            boot_q  <= BOOT;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            boot_q  <= 1'b0;
        end
    end

    // boot_q is high only in the first cycle after reset release.
    assign go   = start | boot_q;
    assign word = boot_q ? BOOT_WORD : data_in;
    assign phase_end = (div_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q + CNT_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (go) begin
                    shreg_d = word;
                    cs_d    = 1'b0;
                    sdo_d   = word[0];
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP, LOW: begin
                if (phase_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        sdo_d   = shreg_q[1];
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = LOW;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    div_d = '0;
                    cs_d  = 1'b1;
                    sdo_d = 1'b0;
                    if (GAP_SKIP) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (div_q == CNT_W'(GAP_END)) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SCLK = sclk_q;
    assign CS   = cs_q;
    assign SDO  = sdo_q;

endmodule

// File: doc/spi_prog_master.md
Name: spi_prog_master

Overview:
- SPI mode-0 transmitter that pushes one DATA_W-bit configuration word to the on-chip programmer interface (SDI/SCLK/CS).
- Sits in the test/bring-up controller on the system clock domain. Drives SCLK, CS and serial data so the receiver shifts on SCLK rising edges while CS is low and latches the word on the CS rising edge.
- Word is sent LSB first, so data_in[0] lands in receiver bit 0 after DATA_W shifts.

Parameters:
- DATA_W, 66, bits per programming word.
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
- CS_GAP, 2, minimum CS-high time after a word, in SCLK half-periods (>=1).
- BOOT_WORD, 0, word auto-sent after reset (used only with PROG_MASTER_BOOT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to send data_in; accepted only when busy=0.
- data_in  input  DATA_W  word to send; captured on the accept cycle.
- busy  output  1  high from the cycle after accept until the done cycle.
- done  output  1  one-cycle pulse when the word is sent and the CS gap has elapsed.
- SCLK  output  1  SPI clock; idles low.
- CS  output  1  chip select, active low; idles high.
- SDO  output  1  serial data to the programmer SDI; idles 0.

Behaviour:
- Reset (async, reset=0): CS=1, SCLK=0, SDO=0, busy=0, done=0, state IDLE, counters 0. All outputs come straight from registers, so they are glitch-free.
- H = CLK_DIV. div_cnt counts H clk cycles per phase. bit_cnt has width clog2(DATA_W).
- IDLE: start=1 and busy=0 captures data_in into shreg, sets CS<=0, SDO<=data_in[0], bit_cnt<=0, and moves to SETUP. busy rises next cycle.
- SETUP: after H cycles, SCLK<=1 and move to HIGH.
- HIGH: after H cycles, SCLK<=0.
  - If bit_cnt==DATA_W-1, move to HOLD.
  - Otherwise shift shreg right, SDO<=next bit, bit_cnt++, move to LOW.
- LOW: after H cycles, SCLK<=1 and move to HIGH.
- SDO changes only on the SCLK falling transition, or at CS fall for bit 0. It is stable for at least H cycles either side of every SCLK rising edge.
- HOLD: after H cycles, CS<=1 and move to GAP. SDO<=0.
- GAP: after CS_GAP*H cycles, done<=1 and busy<=0 in the same cycle, then move to IDLE.
- Timing:
  - Exactly DATA_W SCLK rising edges per word.
  - CS low for exactly (2*DATA_W+1)*H clk cycles.
  - CS high for at least CS_GAP*H cycles between words.
- start is ignored while busy=1, and no queueing is done. A start in the done cycle is accepted, because busy=0 in that cycle.
- data_in changes after the accept cycle have no effect on the word in flight.
- Reset mid-transfer: CS goes high and SCLK low immediately, and the state returns to IDLE. The receiver may latch a partial word on that CS edge; system reset must also reset the receiver. The next start sends a full word.

Optional Feature:
- Macro: PROG_MASTER_BOOT_EN.
- Defined:
  - In the first clk cycle after reset deasserts, the block self-starts one transfer of BOOT_WORD, with the same timing as a start accept.
  - busy=1 during the boot transfer and start is ignored until its done pulse.
  - Boot happens once per reset release.
- Undefined: the block stays in IDLE until start. BOOT_WORD is unused.

Test Plan:
- Reset with reset=0 mid-simulation: within the same cycle CS=1, SCLK=0, SDO=0, busy=0, done=0.
- Default parameters, start with data_in=66'h2_DEAD_BEEF_0123_4567, behavioural programmer receiver attached: 66 SCLK rises, CS low exactly 532 clk, receiver output equals 66'h2_DEAD_BEEF_0123_4567, done high exactly 1 cycle, busy low in that cycle.
- Bit order and setup/hold with data_in=66'h1: SDO=1 only before the first SCLK rise; SDO constant for >=4 clk around every SCLK rise.
- start pulsed at bit 10 of a transfer with different data: ignored and the first word is received intact. Back-to-back: start asserted in the done cycle leaves CS high exactly 8 clk before falling again.
- reset pulsed after 30 SCLK rises: CS/SCLK idle immediately. A following start with 66'h3_FFFF_FFFF_FFFF_FFFF delivers the full word.
- CLK_DIV=1: SCLK period 2 clk, CS low 133 clk, word correct. With PROG_MASTER_BOOT_EN and BOOT_WORD=66'h155: transfer starts 1 cycle after reset release and the receiver reads 66'h155.
